// File: rtl/sine_tx_pkg.sv
// Shared types and constants for the sine-burst transmitter: sample format, state
// encoding and the 20-entry one-period sine table.
package sine_tx_pkg;

  localparam int unsigned NSMP  = 20;
  localparam int unsigned SMP_W = 8;
  localparam int unsigned PH_W  = 5;
  localparam int unsigned BIT_W = 3;
  localparam int unsigned BYTE_W = 8;

  typedef logic signed [SMP_W-1:0] sample_t;
  typedef logic [BYTE_W-1:0]       tx_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  // One full sine period, peak 127 so the BPSK negation always fits in 8 bits.
  function automatic sample_t sine_lut(input logic [PH_W-1:0] ph);
    sample_t v;
    case (ph)
      5'd0:    v = 8'sd0;
      5'd1:    v = 8'sd39;
      5'd2:    v = 8'sd75;
      5'd3:    v = 8'sd103;
      5'd4:    v = 8'sd121;
      5'd5:    v = 8'sd127;
      5'd6:    v = 8'sd121;
      5'd7:    v = 8'sd103;
      5'd8:    v = 8'sd75;
      5'd9:    v = 8'sd39;
      5'd10:   v = 8'sd0;
      5'd11:   v = -8'sd39;
      5'd12:   v = -8'sd75;
      5'd13:   v = -8'sd103;
      5'd14:   v = -8'sd121;
      5'd15:   v = -8'sd127;
      5'd16:   v = -8'sd121;
      5'd17:   v = -8'sd103;
      5'd18:   v = -8'sd75;
      5'd19:   v = -8'sd39;
      default: v = 8'sd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sine_burst_tx_if.sv
// Byte-source handshake into the sine-burst transmitter (valid/ready).
interface sine_burst_tx_if;
  import sine_tx_pkg::*;

  tx_byte_t tx_data;
  logic     tx_valid;
  logic     tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sine_burst_tx_sample_strobe.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and flags the wrap cycle.
module sample_strobe #(
  parameter int unsigned DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  always_comb begin
    wrap  = (cnt_q == CNT_W'(DIV - 1));
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = ena & wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sine_burst_tx.sv
// Byte-to-sine-burst transmitter: one 20-sample sine period per bit, MSB first, BPSK by
// default or on-off keying when SINE_TX_OOK_EN is defined.
module sine_burst_tx
  import sine_tx_pkg::*;
#(
  parameter int unsigned DIV     = 32,
  parameter int unsigned GAP_SMP = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  sine_burst_tx_if.slave        tx_if,
  output sample_t               smp_out,
  output logic                  smp_stb,
  output logic                  busy
);

  localparam int unsigned GAP_W = (GAP_SMP > 1) ? $clog2(GAP_SMP) : 1;

  tx_state_e        state_q, state_d;
  tx_byte_t         shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  sample_t          smp_q, smp_d;
  logic             stb_q, stb_d;
  logic             busy_q, busy_d;

  logic    tick;
  logic    xfer;
  sample_t lut;
  sample_t sym;

  sample_strobe #(.DIV(DIV)) u_strobe (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .tick (tick)
  );

  assign tx_if.tx_ready = (state_q == IDLE) & ena & ~rst;
  assign xfer           = tx_if.tx_valid & tx_if.tx_ready;
  assign lut            = sine_lut(phase_q);

  // Symbol sample for the current bit (MSB of the shifter) at the current phase.
`ifdef SINE_TX_OOK_EN
  assign sym = shreg_q[BYTE_W-1] ? lut : '0;
`else
  assign sym = shreg_q[BYTE_W-1] ? lut : -lut;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    smp_d   = smp_q;
    busy_d  = busy_q;
    stb_d   = tick;

    case (state_q)
      IDLE: begin
        if (tick) begin
          smp_d = '0;
        end
        // A transfer on a tick cycle still emits the idle zero; first symbol goes out next tick.
        if (xfer) begin
          shreg_d = tx_if.tx_data;
          bit_d   = '1;
          phase_d = '0;
          state_d = SEND;
          busy_d  = 1'b1;
        end
      end

      SEND: begin
        if (tick) begin
          smp_d = sym;
          if (phase_q == PH_W'(NSMP - 1)) begin
            phase_d = '0;
            if (bit_q == '0) begin
              if (GAP_SMP > 0) begin
                state_d = GAP;
                gap_d   = '0;
              end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              bit_d   = bit_q - BIT_W'(1);
              shreg_d = {shreg_q[BYTE_W-2:0], 1'b0};
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end

      GAP: begin
        if (tick) begin
          smp_d = '0;
          if (gap_q == GAP_W'(GAP_SMP - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      gap_q   <= '0;
      smp_q   <= '0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      smp_q   <= smp_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
    end
  end

  assign smp_out = smp_q;
  assign smp_stb = stb_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sine_burst_tx.sv
// Directed bench for sine_burst_tx with DIV=4, GAP_SMP=20; expectations follow
// SINE_TX_OOK_EN when that macro is defined.
module tb_sine_burst_tx;

  localparam int unsigned DIV = 4;
  localparam int unsigned GAP = 20;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic signed [7:0] smp_out;
  logic smp_stb;
  logic busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int sine_ref [20] = '{0, 39, 75, 103, 121, 127, 121, 103, 75, 39,
                        0, -39, -75, -103, -121, -127, -121, -103, -75, -39};

  logic signed [7:0] cap_v[$];
  int                cap_t[$];
  bit                cap_en = 1'b0;
  int                xfer_cyc = 0;

  sine_burst_tx_if tx_if ();

  sine_burst_tx #(.DIV(DIV), .GAP_SMP(GAP)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .tx_if   (tx_if),
    .smp_out (smp_out),
    .smp_stb (smp_stb),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (smp_stb === 1'b1 && cap_en && cyc > xfer_cyc) begin
      cap_v.push_back(smp_out);
      cap_t.push_back(cyc);
    end
  end

  function automatic logic signed [7:0] exp_smp(input logic [7:0] b, input int idx);
    int ph;
    logic bv;
    if (idx >= 160) return 8'sd0;
    ph = idx % 20;
    bv = b[7 - idx / 20];
`ifdef SINE_TX_OOK_EN
    return bv ? 8'(sine_ref[ph]) : 8'sd0;
`else
    return bv ? 8'(sine_ref[ph]) : 8'(-sine_ref[ph]);
`endif
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_v.delete();
    cap_t.delete();
    cap_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit hold);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1;
    xfer_cyc = cyc;
    cap_en   = 1'b1;
    if (!hold) tx_if.tx_valid = 1'b0;
  endtask

  task automatic wait_done(output int fall_cyc, output bit timeout);
    timeout  = 1'b1;
    fall_cyc = -1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (busy === 1'b0) begin
        fall_cyc = cyc;
        timeout  = 1'b0;
        break;
      end
    end
    cap_en = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    int bad_iv = 0;
    int first;
    rst = 1'b1; ena = 1'b1; tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;
    repeat (3) step();
    checks++; if (smp_out !== 8'sd0) begin errors++; $display("FAIL rst_smp_out got %0d want 0", smp_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (smp_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %b want 0", smp_stb); end
    checks++; if (tx_if.tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", tx_if.tx_ready); end
    rst = 1'b0;
    #1;
    clear_cap(); xfer_cyc = cyc; cap_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_if.tx_ready !== 1'b1 || busy !== 1'b0 || smp_out !== 8'sd0) bad++;
    end
    cap_en = 1'b0;
    for (int i = 1; i < cap_t.size(); i++) if (cap_t[i] - cap_t[i-1] != 4) bad_iv++;
    first = (cap_t.size() > 0) ? cap_t[0] - xfer_cyc : -1;
    checks++; if (bad != 0) begin errors++; $display("FAIL idle_outputs got %0d bad cycles want 0", bad); end
    checks++; if (cap_t.size() != 25) begin errors++; $display("FAIL idle_stb_count got %0d want 25", cap_t.size()); end
    checks++; if (first != 4) begin errors++; $display("FAIL idle_first_stb got %0d want 4", first); end
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL idle_stb_period got %0d bad intervals want 0", bad_iv); end
  endtask

  task automatic test_bpsk_0x80();
    int fall; bit to; int lat; int bad_iv = 0;
    clear_cap();
    send(8'h80, 1'b0);
    wait_done(fall, to);
    checks++; if (to) begin errors++; $display("FAIL b80_timeout got busy stuck want fall"); end
    checks++; if (cap_v.size() != 180) begin errors++; $display("FAIL b80_count got %0d want 180", cap_v.size()); end
    for (int i = 0; i < cap_v.size() && i < 180; i++) begin
      checks++;
      if (cap_v[i] !== exp_smp(8'h80, i)) begin
        errors++; $display("FAIL b80_smp[%0d] got %0d want %0d", i, cap_v[i], exp_smp(8'h80, i));
      end
    end
    for (int i = 1; i < cap_t.size(); i++) if (cap_t[i] - cap_t[i-1] != 4) bad_iv++;
    lat = (cap_t.size() > 0) ? cap_t[0] - xfer_cyc : -1;
    checks++; if (lat < 1 || lat > 4) begin errors++; $display("FAIL b80_latency got %0d want 1..4", lat); end
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL b80_period got %0d bad intervals want 0", bad_iv); end
    checks++;
    if (cap_t.size() < 180 || fall != cap_t[179]) begin
      errors++; $display("FAIL b80_busy_fall got %0d want last gap tick", fall);
    end
    // Receiver-style correlation of each 20-sample symbol against the template.
    if (cap_v.size() >= 160) begin
      for (int b = 0; b < 8; b++) begin
        int sum = 0; int sgn; int want;
        for (int k = 0; k < 20; k++) sum += sine_ref[k] * int'(cap_v[b*20 + k]);
        sgn = (sum > 0) ? 1 : ((sum < 0) ? -1 : 0);
`ifdef SINE_TX_OOK_EN
        want = (b == 0) ? 1 : 0;
`else
        want = (b == 0) ? 1 : -1;
`endif
        checks++;
        if (sgn != want) begin errors++; $display("FAIL b80_corr[%0d] got %0d want %0d", b, sgn, want); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int fall; bit to; int ready_cyc = -1; int bad_iv = 0; logic signed [7:0] e;
    clear_cap();
    send(8'hA5, 1'b1);
    tx_if.tx_data = 8'h3C;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (tx_if.tx_ready === 1'b1) begin ready_cyc = cyc; break; end
    end
    @(posedge clk);
    #1;
    tx_if.tx_valid = 1'b0;
    wait_done(fall, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got busy stuck want fall"); end
    checks++;
    if (cap_t.size() < 180 || ready_cyc != cap_t[179]) begin
      errors++; $display("FAIL b2b_ready_cyc got %0d want last gap tick of byte 1", ready_cyc);
    end
    checks++; if (cap_v.size() != 360) begin errors++; $display("FAIL b2b_count got %0d want 360", cap_v.size()); end
    for (int i = 0; i < cap_v.size() && i < 360; i++) begin
      e = (i < 180) ? exp_smp(8'hA5, i) : exp_smp(8'h3C, i - 180);
      checks++;
      if (cap_v[i] !== e) begin errors++; $display("FAIL b2b_smp[%0d] got %0d want %0d", i, cap_v[i], e); end
    end
    for (int i = 1; i < cap_t.size(); i++) if (cap_t[i] - cap_t[i-1] != 4) bad_iv++;
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL b2b_period got %0d bad intervals want 0", bad_iv); end
  endtask

  task automatic test_ena_pause();
    int fall; bit to; int bad = 0; int bad_iv = 0; logic signed [7:0] held;
    clear_cap();
    send(8'hC3, 1'b0);
    for (int i = 0; i < 2000 && cap_v.size() < 50; i++) step();
    held = (cap_v.size() >= 50) ? cap_v[49] : 8'sd0;
    checks++; if (cap_v.size() != 50) begin errors++; $display("FAIL ena_reach50 got %0d want 50", cap_v.size()); end
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (smp_stb !== 1'b0 || smp_out !== held || tx_if.tx_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ena_hold got %0d bad cycles want 0", bad); end
    ena = 1'b1;
    wait_done(fall, to);
    checks++; if (to) begin errors++; $display("FAIL ena_timeout got busy stuck want fall"); end
    checks++; if (cap_v.size() != 180) begin errors++; $display("FAIL ena_count got %0d want 180", cap_v.size()); end
    for (int i = 0; i < cap_v.size() && i < 180; i++) begin
      checks++;
      if (cap_v[i] !== exp_smp(8'hC3, i)) begin
        errors++; $display("FAIL ena_smp[%0d] got %0d want %0d", i, cap_v[i], exp_smp(8'hC3, i));
      end
    end
    for (int i = 1; i < cap_t.size(); i++) if (cap_t[i] - cap_t[i-1] != ((i == 50) ? 14 : 4)) bad_iv++;
    checks++; if (bad_iv != 0) begin errors++; $display("FAIL ena_period got %0d bad intervals want 0", bad_iv); end
  endtask

  task automatic test_reset_midframe();
    int fall; bit to; int lat;
    clear_cap();
    send(8'hF0, 1'b0);
    for (int i = 0; i < 2000 && cap_v.size() < 70; i++) step();
    rst = 1'b1;
    step();
    checks++; if (smp_out !== 8'sd0) begin errors++; $display("FAIL rmid_smp_out got %0d want 0", smp_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (smp_stb !== 1'b0) begin errors++; $display("FAIL rmid_stb got %b want 0", smp_stb); end
    rst = 1'b0;
    #1;
    checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", tx_if.tx_ready); end
    clear_cap();
    send(8'h0F, 1'b0);
    wait_done(fall, to);
    lat = (cap_t.size() > 0) ? cap_t[0] - xfer_cyc : -1;
    checks++; if (to) begin errors++; $display("FAIL rmid_timeout got busy stuck want fall"); end
    checks++; if (lat != 3) begin errors++; $display("FAIL rmid_latency got %0d want 3", lat); end
    checks++; if (cap_v.size() != 180) begin errors++; $display("FAIL rmid_count got %0d want 180", cap_v.size()); end
    for (int i = 0; i < cap_v.size() && i < 180; i++) begin
      checks++;
      if (cap_v[i] !== exp_smp(8'h0F, i)) begin
        errors++; $display("FAIL rmid_smp[%0d] got %0d want %0d", i, cap_v[i], exp_smp(8'h0F, i));
      end
    end
  endtask

  task automatic test_keying_0x55();
    int fall; bit to; int lat;
    clear_cap();
    for (int i = 0; i < 20; i++) begin
      step();
      if (smp_stb === 1'b1) break;
    end
    repeat (3) step();
    send(8'h55, 1'b0);
    wait_done(fall, to);
    lat = (cap_t.size() > 0) ? cap_t[0] - xfer_cyc : -1;
    checks++; if (to) begin errors++; $display("FAIL k55_timeout got busy stuck want fall"); end
    checks++; if (lat != 4) begin errors++; $display("FAIL k55_tick_xfer_latency got %0d want 4", lat); end
    checks++; if (cap_v.size() != 180) begin errors++; $display("FAIL k55_count got %0d want 180", cap_v.size()); end
    for (int i = 0; i < cap_v.size() && i < 180; i++) begin
      checks++;
      if (cap_v[i] !== exp_smp(8'h55, i)) begin
        errors++; $display("FAIL k55_smp[%0d] got %0d want %0d", i, cap_v[i], exp_smp(8'h55, i));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    test_reset();
    test_bpsk_0x80();
    test_back_to_back();
    test_ena_pause();
    test_reset_midframe();
    test_keying_0x55();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
